// File: rtl/mult_div_pkg.sv
// Shared encodings for the multiply/divide sequencer: opcodes, FSM states, latencies, flag bit positions.
// Pure declarations; no latency or flow control of its own.
package mult_div_pkg;

  localparam logic [1:0] OP_MULU = 2'd0;
  localparam logic [1:0] OP_MULS = 2'd1;
  localparam logic [1:0] OP_DIVU = 2'd2;
  localparam logic [1:0] OP_DIVS = 2'd3;

  localparam int DEF_MUL_LATENCY = 18;
  localparam int DEF_DIV_LATENCY = 30;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] result;
    logic [3:0]  flags;
  } pack_t;

  function automatic logic is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/mult_div_pack.sv
// Combinational 68000 result packing and NZVC generation from the unit outputs; zero latency.
// No flow control: output is sampled by the sequencer only at capture.
module mult_div_pack
  import mult_div_pkg::*;
(
  input  logic [1:0]  i_op,
  input  logic [31:0] i_dst,
  input  logic [31:0] i_divu_quotient,
  input  logic [31:0] i_divs_quotient,
  input  logic [15:0] i_divu_remainder,
  input  logic [15:0] i_divs_remainder,
  input  logic [31:0] i_mulu_result,
  input  logic [31:0] i_muls_result,
  output pack_t       o_pack
);

  logic [31:0] w_quot;
  logic [15:0] w_rem;
  logic [31:0] w_prod;
  logic        w_ovf;

  always_comb begin
    w_quot = i_op[0] ? i_divs_quotient  : i_divu_quotient;
    w_rem  = i_op[0] ? i_divs_remainder : i_divu_remainder;
    w_prod = i_op[0] ? i_muls_result    : i_mulu_result;
    // Signed quotient fits 16 bits only if bits [31:15] are a pure sign extension.
    if (i_op == OP_DIVS)
      w_ovf = !((w_quot[31:15] == 17'h0) || (w_quot[31:15] == 17'h1FFFF));
    else
      w_ovf = (w_quot[31:16] != 16'h0);
  end

  always_comb begin
    o_pack = '0;
    if (!is_div(i_op)) begin
      o_pack.result        = w_prod;
      o_pack.flags[FLAG_N] = w_prod[31];
      o_pack.flags[FLAG_Z] = (w_prod == 32'h0);
    end else if (w_ovf) begin
      o_pack.result        = i_dst;
      o_pack.flags[FLAG_V] = 1'b1;
    end else begin
      o_pack.result        = {w_rem, w_quot[15:0]};
      o_pack.flags[FLAG_N] = w_quot[15];
      o_pack.flags[FLAG_Z] = (w_quot[15:0] == 16'h0);
    end
  end

endmodule

// File: rtl/mult_div_sequencer.sv
// Issues one MUL/DIV to the pipelined unit, waits LAT clocks, packs the result; done LAT+2 cycles after start.
// start is ignored while busy; divide-by-zero completes next cycle without touching the unit.
module mult_div_sequencer
  import mult_div_pkg::*;
#(
  parameter int MUL_LATENCY = DEF_MUL_LATENCY,
  parameter int DIV_LATENCY = DEF_DIV_LATENCY
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] dst,
  input  logic [15:0] src,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [3:0]  flags,
  output logic        div_zero,
  output logic [31:0] operand1,
  output logic [31:0] operand2,
  input  logic [31:0] divu_quotient,
  input  logic [31:0] divs_quotient,
  input  logic [15:0] divu_remainder,
  input  logic [15:0] divs_remainder,
  input  logic [31:0] mulu_result,
  input  logic [31:0] muls_result
);

  localparam int MAX_LAT = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         r_op;
  logic [31:0]        r_operand1;
  logic [31:0]        r_operand2;
  logic [31:0]        r_result;
  logic [3:0]         r_flags;
  logic               r_div_zero;
  logic               w_accept;
  logic               w_dz;
  logic               w_capture;
  pack_t              w_pack;

  mult_div_pack u_pack (
    .i_op             (r_op),
    .i_dst            (r_operand1),
    .i_divu_quotient  (divu_quotient),
    .i_divs_quotient  (divs_quotient),
    .i_divu_remainder (divu_remainder),
    .i_divs_remainder (divs_remainder),
    .i_mulu_result    (mulu_result),
    .i_muls_result    (muls_result),
    .o_pack           (w_pack)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_dz        = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (is_div(op) && (src == 16'h0)) begin
            w_dz        = 1'b1;
            w_state_nxt = ST_DONE;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = ST_WAIT;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_op       <= OP_MULU;
      r_operand1 <= '0;
      r_operand2 <= '0;
      r_result   <= '0;
      r_flags    <= '0;
      r_div_zero <= 1'b0;
    end else begin
      if (w_accept) begin
        r_operand1 <= dst;
        r_operand2 <= {16'h0, src};
        r_op       <= op;
        r_cnt      <= is_div(op) ? CNT_W'(DIV_LATENCY) : CNT_W'(MUL_LATENCY);
      end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end

      // Divide-by-zero leaves the destination untouched and raises the trap.
      if (w_dz) begin
        r_result   <= dst;
        r_flags    <= 4'b0000;
        r_div_zero <= 1'b1;
      end else if (w_capture) begin
        r_result   <= w_pack.result;
        r_flags    <= w_pack.flags;
        r_div_zero <= 1'b0;
      end
    end
  end

  assign busy     = (r_state == ST_WAIT);
  assign done     = (r_state == ST_DONE);
  assign result   = r_result;
  assign flags    = r_flags;
  assign div_zero = r_div_zero;
  assign operand1 = r_operand1;
  assign operand2 = r_operand2;

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Directed bench: table of operations against a delayed behavioural model of the multiply/divide unit,
// plus hand sequences for reset during WAIT and back-to-back issue in the DONE cycle.
module tb_mult_div_sequencer;
  import mult_div_pkg::*;

  localparam int MUL_LAT = 18;
  localparam int DIV_LAT = 30;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op    = 2'd0;
  logic [31:0] dst   = 32'h0;
  logic [15:0] src   = 16'h0;
  logic        busy, done, div_zero;
  logic [31:0] result, operand1, operand2;
  logic [3:0]  flags;
  logic [31:0] divu_quotient, divs_quotient, mulu_result, muls_result;
  logic [15:0] divu_remainder, divs_remainder;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_op1 = 32'h0;
  logic [31:0] exp_op2 = 32'h0;

  always #5 clock = ~clock;

  mult_div_sequencer #(.MUL_LATENCY(MUL_LAT), .DIV_LATENCY(DIV_LAT)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .dst(dst), .src(src),
    .busy(busy), .done(done), .result(result), .flags(flags), .div_zero(div_zero),
    .operand1(operand1), .operand2(operand2),
    .divu_quotient(divu_quotient), .divs_quotient(divs_quotient),
    .divu_remainder(divu_remainder), .divs_remainder(divs_remainder),
    .mulu_result(mulu_result), .muls_result(muls_result)
  );

  // Behavioural unit: arithmetic on the operand registers, delayed by the pipeline depth.
  logic [15:0] m_a, m_b;
  logic [31:0] m_mulu, m_muls, m_divu_q, m_divs_q;
  logic [15:0] m_divu_r, m_divs_r;
  always_comb begin
    m_a    = operand1[15:0];
    m_b    = operand2[15:0];
    m_mulu = {16'h0, m_a} * {16'h0, m_b};
    m_muls = $signed({{16{m_a[15]}}, m_a}) * $signed({{16{m_b[15]}}, m_b});
    if (m_b == 16'h0) begin
      m_divu_q = 32'h0; m_divu_r = 16'h0; m_divs_q = 32'h0; m_divs_r = 16'h0;
    end else begin
      m_divu_q = operand1 / {16'h0, m_b};
      m_divu_r = 16'(operand1 % {16'h0, m_b});
      m_divs_q = 32'($signed(operand1) / $signed({{16{m_b[15]}}, m_b}));
      m_divs_r = 16'($signed(operand1) % $signed({{16{m_b[15]}}, m_b}));
    end
  end

  logic [31:0] p_mulu [MUL_LAT];
  logic [31:0] p_muls [MUL_LAT];
  logic [31:0] p_divu_q [DIV_LAT];
  logic [31:0] p_divs_q [DIV_LAT];
  logic [15:0] p_divu_r [DIV_LAT];
  logic [15:0] p_divs_r [DIV_LAT];

  always @(posedge clock) begin
    for (int i = MUL_LAT - 1; i > 0; i--) begin
      p_mulu[i] <= p_mulu[i-1];
      p_muls[i] <= p_muls[i-1];
    end
    p_mulu[0] <= m_mulu;
    p_muls[0] <= m_muls;
    for (int j = DIV_LAT - 1; j > 0; j--) begin
      p_divu_q[j] <= p_divu_q[j-1];
      p_divs_q[j] <= p_divs_q[j-1];
      p_divu_r[j] <= p_divu_r[j-1];
      p_divs_r[j] <= p_divs_r[j-1];
    end
    p_divu_q[0] <= m_divu_q;
    p_divs_q[0] <= m_divs_q;
    p_divu_r[0] <= m_divu_r;
    p_divs_r[0] <= m_divs_r;
  end

  assign mulu_result    = p_mulu[MUL_LAT-1];
  assign muls_result    = p_muls[MUL_LAT-1];
  assign divu_quotient  = p_divu_q[DIV_LAT-1];
  assign divs_quotient  = p_divs_q[DIV_LAT-1];
  assign divu_remainder = p_divu_r[DIV_LAT-1];
  assign divs_remainder = p_divs_r[DIV_LAT-1];

  typedef struct {
    logic [1:0]  op;
    logic [31:0] dst;
    logic [15:0] src;
    logic [31:0] exp_res;
    logic [3:0]  exp_flg;
    logic        exp_dz;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  // Issues one operation and checks completion; with now=1 the start is driven in the current cycle.
  task automatic run_op(input vec_t v, input bit now, input string tag);
    int cyc;
    bit got;
    bit busy_bad;
    if (!now) @(negedge clock);
    start = 1'b1; op = v.op; dst = v.dst; src = v.src;
    cyc = 0; got = 1'b0; busy_bad = 1'b0;
    while (!got && cyc < 100) begin
      @(negedge clock);
      cyc++;
      start = 1'b0;
      if (done) begin
        got = 1'b1;
        if (busy) busy_bad = 1'b1;
      end else if (busy !== !v.exp_dz) begin
        busy_bad = 1'b1;
      end
    end
    if (!v.exp_dz) begin
      exp_op1 = v.dst;
      exp_op2 = {16'h0, v.src};
    end
    chk({tag, " done_cycle"}, 32'(cyc), 32'(v.exp_cyc));
    chk({tag, " result"}, result, v.exp_res);
    chk({tag, " flags"}, {28'h0, flags}, {28'h0, v.exp_flg});
    chk({tag, " div_zero"}, {31'h0, div_zero}, {31'h0, v.exp_dz});
    chk({tag, " busy_profile"}, {31'h0, busy_bad}, 32'h0);
    chk({tag, " operand1"}, operand1, exp_op1);
    chk({tag, " operand2"}, operand2, exp_op2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t hv;
    bit   spur;
    vecs[0]  = '{OP_MULU, 32'h0000FFFF, 16'hFFFF, 32'hFFFE0001, 4'b1000, 1'b0, 20};
    vecs[1]  = '{OP_MULS, 32'h0000FFFF, 16'h0002, 32'hFFFFFFFE, 4'b1000, 1'b0, 20};
    vecs[2]  = '{OP_MULU, 32'h00001234, 16'h0000, 32'h00000000, 4'b0100, 1'b0, 20};
    vecs[3]  = '{OP_DIVU, 32'd100000,   16'd7,    32'h000537CD, 4'b0000, 1'b0, 32};
    vecs[4]  = '{OP_DIVS, 32'hFFFFFFF9, 16'h0002, 32'hFFFFFFFD, 4'b1000, 1'b0, 32};
    vecs[5]  = '{OP_DIVU, 32'h00100000, 16'h0001, 32'h00100000, 4'b0010, 1'b0, 32};
    vecs[6]  = '{OP_DIVS, 32'h00008000, 16'h0001, 32'h00008000, 4'b0010, 1'b0, 32};
    vecs[7]  = '{OP_DIVU, 32'h12345678, 16'h0000, 32'h12345678, 4'b0000, 1'b1, 1};
    vecs[8]  = '{OP_DIVS, 32'h00000000, 16'h0005, 32'h00000000, 4'b0100, 1'b0, 32};
    vecs[9]  = '{OP_DIVS, 32'hFFFF8000, 16'h0001, 32'h00008000, 4'b1000, 1'b0, 32};
    vecs[10] = '{OP_MULS, 32'h00008000, 16'h8000, 32'h40000000, 4'b0000, 1'b0, 20};
    vecs[11] = '{OP_DIVS, 32'd100,      16'hFFF9, 32'h0002FFF2, 4'b1000, 1'b0, 32};
    vecs[12] = '{OP_DIVS, 32'hFFFFFF9C, 16'h0007, 32'hFFFEFFF2, 4'b1000, 1'b0, 32};
    vecs[13] = '{OP_DIVS, 32'h00000010, 16'h0000, 32'h00000010, 4'b0000, 1'b1, 1};

    // Reset state
    @(negedge clock);
    chk("reset busy", {31'h0, busy}, 32'h0);
    chk("reset done", {31'h0, done}, 32'h0);
    chk("reset result", result, 32'h0);
    chk("reset operand1", operand1, 32'h0);
    @(negedge clock);
    reset = 1'b0;

    for (int k = 0; k < 14; k++)
      run_op(vecs[k], 1'b0, $sformatf("vec%0d", k));

    // Reset asserted in WAIT cycle 10 clears everything and cancels the operation.
    @(negedge clock);
    start = 1'b1; op = OP_MULU; dst = 32'h0000ABCD; src = 16'h1234;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    chk("wait busy before reset", {31'h0, busy}, 32'h1);
    #1 reset = 1'b1;
    #1;
    chk("midrst busy", {31'h0, busy}, 32'h0);
    chk("midrst done", {31'h0, done}, 32'h0);
    chk("midrst result", result, 32'h0);
    chk("midrst flags", {28'h0, flags}, 32'h0);
    chk("midrst div_zero", {31'h0, div_zero}, 32'h0);
    chk("midrst operand1", operand1, 32'h0);
    chk("midrst operand2", operand2, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    exp_op1 = 32'h0;
    exp_op2 = 32'h0;
    spur = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (done || busy) spur = 1'b1;
    end
    chk("post reset idle", {31'h0, spur}, 32'h0);
    hv = '{OP_MULU, 32'h00001234, 16'h0100, 32'h00123400, 4'b0000, 1'b0, 20};
    run_op(hv, 1'b0, "after_reset");

    // Back-to-back: second start in the DONE cycle of the first.
    hv = '{OP_MULS, 32'h0000FFFE, 16'hFFFD, 32'h00000006, 4'b0000, 1'b0, 20};
    run_op(hv, 1'b0, "b2b_first");
    hv = '{OP_DIVU, 32'd100000, 16'd7, 32'h000537CD, 4'b0000, 1'b0, 32};
    run_op(hv, 1'b1, "b2b_second");
    hv = '{OP_DIVU, 32'h00000055, 16'h0000, 32'h00000055, 4'b0000, 1'b1, 1};
    run_op(hv, 1'b1, "b2b_divzero");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
